mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port memory arbiter between the core's instruction-fetch port and its data port on one side and a single shared memory bus on the other. It serialises requests so that only one is outstanding at a time, round-robins on conflicts, and answers each requester with a one-cycle valid pulse. A watchdog aborts hung transactions so the core cannot stall forever.

## Interface
- TIMEOUT, 255: response-wait cycles before abort; legal range 1..65535.
- ERR_DATA, 32'hDEADBEEF: read data returned on timeout.
---
- clk  in  1  clock, rising edge.
- res  in  1  reset, asynchronous, active-high.
- instr_req  in  1  fetch request; held with instr_addr stable until instr_valid.
- instr_addr  in  32  fetch byte address.
- instr_read  out  32  fetched word; meaningful only while instr_valid=1.
- instr_valid  out  1  one-cycle completion pulse for fetch.
- data_req  in  1  data request; held with addr/write/we/be stable until data_valid.
- data_addr  in  32  data byte address.
- data_write  in  32  store data.
- data_write_enable  in  1  1 = store, 0 = load.
- data_be  in  4  byte enables.
- data_read  out  32  load data; meaningful only while data_valid=1.
- data_valid  out  1  one-cycle completion pulse for load or store.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepted the request this cycle (mem_req & mem_gnt).
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_rvalid  in  1  response strobe; exactly one per accepted request, reads and writes alike.
- mem_rdata  in  32  response data.
- bus_err  out  1  one-cycle pulse, coincident with the valid pulse of a timed-out transaction.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: a port is eligible if its req=1 and its own valid is not asserted this cycle, which prevents re-issuing a just-answered request. When eligible ports exist, select the winner, latch its addr, wdata, we and be into mem_* registers, and go to REQ.
  - Only one eligible: it wins.
  - Both eligible: the port not granted last wins. The last-grant flag updates on every selection.
- Instr port selections drive mem_we=0 and mem_be=4'hF. Data port selections pass its signals through unchanged.
- REQ: mem_req=1, and mem_* stays stable until mem_gnt=1. On grant, go to RESP and clear the watchdog.
- RESP: mem_req=0. The watchdog increments each cycle.
  - On mem_rvalid=1: register mem_rdata into the winner's read output, pulse its valid on the next cycle, and go to IDLE.
  - If the watchdog reaches TIMEOUT without mem_rvalid: pulse the winner's valid with read data = ERR_DATA, pulse bus_err, and go to IDLE.
- mem_rvalid is ignored in IDLE and REQ, including a late response to an aborted transaction.
- A requester dropping req while in REQ or RESP is a protocol violation; the transaction still completes.
- The REQ state has no timeout.

## Timing
- Reset (async, any state): state=IDLE; mem_req=0; mem_addr, mem_wdata, mem_be, mem_we=0; instr_valid, data_valid, bus_err=0; instr_read, data_read=0; watchdog=0; last-grant=instr (data wins the first conflict).
- All outputs are registered. No combinational path from any input to any output.
- Minimum latency with a zero-wait memory (gnt in the first REQ cycle, rvalid the cycle after):
  - cycle 0: req sampled in IDLE.
  - cycle 1: mem_req=1, gnt.
  - cycle 2: rvalid.
  - cycle 3: valid pulse.
  - Request-to-valid is 3 cycles.
- Back-to-back on the same port: the valid cycle is IDLE with that port masked, so the next issue is sampled the cycle after valid. Throughput is 1 transaction per 4 cycles.
- The other port is not masked in the valid cycle, so on a conflict the loser is selected in that same IDLE cycle.
- Timeout: valid and bus_err are asserted exactly TIMEOUT+1 cycles after the grant cycle.
- Watchdog width is 16 bits and never wraps, because it stops at TIMEOUT.

## Test plan
- Single fetch:
  - Stimulus: instr_req=1, addr 0x100; memory gnt immediate, rvalid next cycle with 0x00500093.
  - Response: mem_we=0, mem_be=F; instr_valid pulses 3 cycles after req with instr_read=0x00500093; data_valid stays 0.
- Store:
  - Stimulus: data_req with we=1, addr 0x2004, wdata 0xCAFEBABE, be=4'b0011.
  - Response: mem_* carries these exact values while mem_req=1; a single data_valid pulse follows.
- Conflict and fairness:
  - Stimulus: both reqs held high from reset for 4 transactions.
  - Response: grant order is data, instr, data, instr; no port is granted twice in a row; each valid is exactly one cycle.
- Grant stall:
  - Stimulus: mem_gnt held low for 5 cycles.
  - Response: mem_req stays 1 and mem_addr is stable for all 5 cycles; completion follows normally.
- Timeout:
  - Stimulus: TIMEOUT=4, data load granted, no rvalid; a late rvalid arrives 10 cycles later.
  - Response: data_valid and bus_err pulse together with data_read=0xDEADBEEF; the late rvalid produces no pulse.
- Reset mid-RESP:
  - Stimulus: assert res asynchronously while in RESP, then deliver rvalid after release.
  - Response: all outputs 0 immediately; no valid pulse; the next instr_req is served normally, and data wins the next conflict.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that merges the instruction-fetch and data ports onto one
// memory bus with a single outstanding transaction and a response watchdog.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        res,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_read,
  output logic        instr_valid,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write,
  input  logic        data_write_enable,
  input  logic [3:0]  data_be,
  output logic [31:0] data_read,
  output logic        data_valid,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  // Abort is decided one cycle early so the registered pulse lands TIMEOUT+1
  // cycles after the grant.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wd_q;
  logic        last_data_q;
  logic        win_data_q;
  logic        instr_elig, data_elig;
  logic        issue, pick_data, resp_ok, resp_abort;

  // A port whose valid is high this cycle was just answered; masking it stops
  // the still-held request from being issued a second time.
  assign instr_elig = instr_req & ~instr_valid;
  assign data_elig  = data_req  & ~data_valid;

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    pick_data  = 1'b0;
    resp_ok    = 1'b0;
    resp_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_elig || data_elig) begin
          issue     = 1'b1;
          pick_data = data_elig & (~instr_elig | ~last_data_q);
          state_d   = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) state_d = RESP;
      end
      RESP: begin
        if (mem_rvalid) begin
          resp_ok = 1'b1;
          state_d = IDLE;
        end else if (wd_q == WD_LAST) begin
          resp_abort = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      bus_err     <= 1'b0;
      instr_read  <= '0;
      data_read   <= '0;
      wd_q        <= '0;
      last_data_q <= 1'b0;
      win_data_q  <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      bus_err     <= 1'b0;

      if (issue) begin
        mem_req     <= 1'b1;
        win_data_q  <= pick_data;
        last_data_q <= pick_data;
        if (pick_data) begin
          mem_addr  <= data_addr;
          mem_wdata <= data_write;
          mem_we    <= data_write_enable;
          mem_be    <= data_be;
        end else begin
          mem_addr  <= instr_addr;
          mem_wdata <= '0;
          mem_we    <= 1'b0;
          mem_be    <= 4'hF;
        end
      end

      if (state_q == REQ && mem_gnt) begin
        mem_req <= 1'b0;
        wd_q    <= '0;
      end

      // Counter holds once the abort fires, so it can never wrap.
      if (state_q == RESP && !resp_ok && !resp_abort) wd_q <= wd_q + 16'd1;

      if (resp_ok || resp_abort) begin
        bus_err <= resp_abort;
        if (win_data_q) begin
          data_valid <= 1'b1;
          data_read  <= resp_ok ? mem_rdata : ERR_DATA;
        end else begin
          instr_valid <= 1'b1;
          instr_read  <= resp_ok ? mem_rdata : ERR_DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-by-cycle bench for mem_arbiter with TIMEOUT=4; the memory side
// is driven by hand and every expected value is written out explicitly.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_read;
  logic        instr_valid;
  logic        data_req;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic        data_write_enable;
  logic [3:0]  data_be;
  logic [31:0] data_read;
  logic        data_valid;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_data;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk               (clk),
    .res               (res),
    .instr_req         (instr_req),
    .instr_addr        (instr_addr),
    .instr_read        (instr_read),
    .instr_valid       (instr_valid),
    .data_req          (data_req),
    .data_addr         (data_addr),
    .data_write        (data_write),
    .data_write_enable (data_write_enable),
    .data_be           (data_be),
    .data_read         (data_read),
    .data_valid        (data_valid),
    .mem_req           (mem_req),
    .mem_gnt           (mem_gnt),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_we            (mem_we),
    .mem_be            (mem_be),
    .mem_rvalid        (mem_rvalid),
    .mem_rdata         (mem_rdata),
    .bus_err           (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"},     32'(mem_req),     32'h0);
    chk({tag, "_mem_addr"},    mem_addr,         32'h0);
    chk({tag, "_mem_wdata"},   mem_wdata,        32'h0);
    chk({tag, "_mem_we"},      32'(mem_we),      32'h0);
    chk({tag, "_mem_be"},      32'(mem_be),      32'h0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_data_valid"},  32'(data_valid),  32'h0);
    chk({tag, "_bus_err"},     32'(bus_err),     32'h0);
    chk({tag, "_instr_read"},  instr_read,       32'h0);
    chk({tag, "_data_read"},   data_read,        32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    res = 1'b1;
    instr_req = 0; instr_addr = 0;
    data_req = 0; data_addr = 0; data_write = 0; data_write_enable = 0; data_be = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    res = 1'b0;

    // Single fetch, zero-wait memory: valid 3 cycles after request
    instr_req = 1; instr_addr = 32'h100; mem_gnt = 1;
    tick();
    chk("fetch_req",    32'(mem_req),     32'h1);
    chk("fetch_addr",   mem_addr,         32'h100);
    chk("fetch_we",     32'(mem_we),      32'h0);
    chk("fetch_be",     32'(mem_be),      32'hF);
    tick();
    chk("fetch_req_off", 32'(mem_req),    32'h0);
    mem_rvalid = 1; mem_rdata = 32'h00500093;
    tick();
    mem_rvalid = 0;
    chk("fetch_valid",  32'(instr_valid), 32'h1);
    chk("fetch_read",   instr_read,       32'h00500093);
    chk("fetch_dvalid", 32'(data_valid),  32'h0);
    instr_req = 0;
    tick();
    chk("fetch_pulse",  32'(instr_valid), 32'h0);
    chk("fetch_idle",   32'(mem_req),     32'h0);

    // Store
    data_req = 1; data_write_enable = 1; data_addr = 32'h2004;
    data_write = 32'hCAFEBABE; data_be = 4'b0011;
    tick();
    chk("st_req",   32'(mem_req), 32'h1);
    chk("st_addr",  mem_addr,     32'h2004);
    chk("st_wdata", mem_wdata,    32'hCAFEBABE);
    chk("st_we",    32'(mem_we),  32'h1);
    chk("st_be",    32'(mem_be),  32'h3);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h0;
    tick();
    mem_rvalid = 0;
    chk("st_valid",  32'(data_valid),  32'h1);
    chk("st_ivalid", 32'(instr_valid), 32'h0);
    data_req = 0; data_write_enable = 0;
    tick();
    chk("st_pulse",  32'(data_valid),  32'h0);

    // Conflict from reset: data first, then strict alternation
    instr_req = 1; instr_addr = 32'h1000;
    data_req = 1; data_addr = 32'h2000; data_write_enable = 0; data_be = 4'hF;
    mem_gnt = 1;
    do_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_data = (k % 2 == 0);
      chk("cf_req",  32'(mem_req), 32'h1);
      chk("cf_addr", mem_addr, exp_data ? 32'h2000 : 32'h1000);
      if (k > 0) begin
        chk("cf_ipulse", 32'(instr_valid), 32'h0);
        chk("cf_dpulse", 32'(data_valid),  32'h0);
      end
      tick();
      mem_rvalid = 1; mem_rdata = 32'hA0000000 + 32'(k);
      tick();
      mem_rvalid = 0;
      chk("cf_dvalid", 32'(data_valid),  32'(exp_data));
      chk("cf_ivalid", 32'(instr_valid), 32'(!exp_data));
      chk("cf_rdata", exp_data ? data_read : instr_read, 32'hA0000000 + 32'(k));
      if (k == 3) begin
        instr_req = 0; data_req = 0;
      end
      tick();
    end
    chk("cf_end_ivalid", 32'(instr_valid), 32'h0);
    chk("cf_end_req",    32'(mem_req),     32'h0);

    // Grant stall: request and address hold for 5 cycles without grant
    instr_req = 1; instr_addr = 32'h300; mem_gnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req",  32'(mem_req), 32'h1);
      chk("stall_addr", mem_addr,     32'h300);
    end
    tick();
    chk("stall_req6", 32'(mem_req), 32'h1);
    mem_gnt = 1;
    tick();
    chk("stall_resp", 32'(mem_req), 32'h0);
    mem_rvalid = 1; mem_rdata = 32'h11112222;
    tick();
    mem_rvalid = 0;
    chk("stall_valid", 32'(instr_valid), 32'h1);
    chk("stall_read",  instr_read,       32'h11112222);
    instr_req = 0;
    tick();

    // Timeout: grant at cycle 1, abort pulse at cycle 1+TIMEOUT+1 = 6
    data_req = 1; data_addr = 32'h4000; data_write_enable = 0; data_be = 4'hF;
    tick();
    chk("to_req", 32'(mem_req), 32'h1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("to_early_valid", 32'(data_valid), 32'h0);
      chk("to_early_err",   32'(bus_err),    32'h0);
    end
    tick();
    chk("to_valid",  32'(data_valid),  32'h1);
    chk("to_err",    32'(bus_err),     32'h1);
    chk("to_read",   data_read,        32'hDEADBEEF);
    chk("to_ivalid", 32'(instr_valid), 32'h0);
    data_req = 0;
    tick();
    chk("to_pulse_valid", 32'(data_valid), 32'h0);
    chk("to_pulse_err",   32'(bus_err),    32'h0);
    repeat (9) tick();
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 0;
    chk("late_dvalid", 32'(data_valid),  32'h0);
    chk("late_ivalid", 32'(instr_valid), 32'h0);
    chk("late_err",    32'(bus_err),     32'h0);
    tick();
    chk("late_dvalid2", 32'(data_valid), 32'h0);

    // Reset while in RESP
    instr_req = 1; instr_addr = 32'h500;
    tick();
    chk("mid_addr", mem_addr, 32'h500);
    tick();
    #2;
    res = 1'b1;
    instr_req = 0;
    #1;
    chk_zero("mid_rst");
    @(posedge clk);
    #1;
    res = 1'b0;
    mem_rvalid = 1; mem_rdata = 32'h55555555;
    tick();
    mem_rvalid = 0;
    chk("mid_ivalid", 32'(instr_valid), 32'h0);
    chk("mid_dvalid", 32'(data_valid),  32'h0);
    chk("mid_req",    32'(mem_req),     32'h0);

    instr_req = 1; instr_addr = 32'h600;
    tick();
    chk("post_req",  32'(mem_req), 32'h1);
    chk("post_addr", mem_addr,     32'h600);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h66666666;
    tick();
    mem_rvalid = 0;
    chk("post_valid", 32'(instr_valid), 32'h1);
    chk("post_read",  instr_read,       32'h66666666);
    instr_req = 0;
    tick();

    instr_req = 1; instr_addr = 32'h700;
    data_req = 1; data_addr = 32'h800;
    tick();
    chk("post_cf_first", mem_addr, 32'h800);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h88888888;
    tick();
    mem_rvalid = 0;
    chk("post_cf_dvalid", 32'(data_valid), 32'h1);
    chk("post_cf_dread",  data_read,       32'h88888888);
    data_req = 0;
    tick();
    chk("post_cf_second", mem_addr, 32'h700);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h77777777;
    tick();
    mem_rvalid = 0;
    chk("post_cf_ivalid", 32'(instr_valid), 32'h1);
    chk("post_cf_iread",  instr_read,       32'h77777777);
    instr_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
